// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage selectors: occupancy encoding and default NOP word.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  localparam int          NOP_W       = 32;
  localparam logic [31:0] NOP_DEFAULT = '0;

endpackage

// File: rtl/mux_pipe_stage_if.sv
// Upstream/downstream handshake bundle for mux_pipe_stage; slave is the stage, master drives it.
interface mux_pipe_stage_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              occupancy;
  logic                    sel_err;

  modport slave (
    input  sel, in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, occupancy, sel_err
  );

  modport master (
    output sel, in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, occupancy, sel_err
  );
endinterface

// File: rtl/mux_nx1_param.sv
// Combinational N-way word selector; out-of-range selects yield NOP_VALUE and raise sel_illegal.
module mux_nx1_param #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  localparam int              SEL_W     = $clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]        sel_word,
  output logic                    sel_illegal
);

  always_comb begin
    sel_word    = NOP_VALUE;
    sel_illegal = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word    = in_data[k*WIDTH +: WIDTH];
        sel_illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N-way selector stage with valid/ready handshake and a one-entry skid buffer.
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0
//   ST_ONE   | main register holds the output word
//   ST_TWO   | main and skid both full, in_ready=0
module mux_pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  mux_pipe_stage_if.slave  bus
);

  localparam int SEL_W = $clog2(NUM_IN);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;
  logic [WIDTH-1:0] sel_word;
  logic             sel_illegal;
  logic             out_valid;
  logic             accept;
  logic             drain;

  mux_nx1_param #(
    .WIDTH     (WIDTH),
    .NUM_IN    (NUM_IN),
    .NOP_VALUE (NOP_VALUE)
  ) u_sel (
    .sel         (bus.sel[SEL_W-1:0]),
    .in_data     (bus.in_data),
    .sel_word    (sel_word),
    .sel_illegal (sel_illegal)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign drain     = out_valid & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    sel_err_d = sel_err_q | (accept & sel_illegal);

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = sel_word;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = sel_word;
        end else if (accept) begin
          skid_d  = sel_word;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A flushed word is discarded entirely, so it must not mark sel_err either.
    if (bus.flush) begin
      state_d   = ST_EMPTY;
      main_d    = NOP_VALUE;
      sel_err_d = sel_err_q;
    end

    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= NOP_VALUE;
      skid_q     <= NOP_VALUE;
      in_ready_q <= 1'b1;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = main_q;
  assign bus.out_valid = out_valid;
  assign bus.occupancy = state_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Directed bench for mux_pipe_stage: a 4-input and a 3-input instance on a shared clock.
module tb_mux_pipe_stage;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_pipe_stage_if #(.WIDTH(32), .NUM_IN(4)) bus_a ();
  mux_pipe_stage_if #(.WIDTH(32), .NUM_IN(3)) bus_b ();

  mux_pipe_stage #(.WIDTH(32), .NUM_IN(4), .NOP_VALUE(32'h0)) u_dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  mux_pipe_stage #(.WIDTH(32), .NUM_IN(3), .NOP_VALUE(32'h0)) u_dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic ov, input logic [31:0] od,
                       input logic ir, input logic [1:0] occ, input logic se);
    chk({tag, ".out_valid"}, 32'(bus_a.out_valid), 32'(ov));
    chk({tag, ".out_data"},  bus_a.out_data,       od);
    chk({tag, ".in_ready"},  32'(bus_a.in_ready),  32'(ir));
    chk({tag, ".occupancy"}, 32'(bus_a.occupancy), 32'(occ));
    chk({tag, ".sel_err"},   32'(bus_a.sel_err),   32'(se));
  endtask

  task automatic offer_a(input logic [1:0] s, input logic [31:0] w);
    bus_a.in_valid = 1'b1;
    bus_a.sel      = s;
    bus_a.in_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus_a.in_data[s*32 +: 32] = w;
  endtask

  initial begin
    bus_a.sel = '0; bus_a.in_data = '0; bus_a.in_valid = 0; bus_a.flush = 0; bus_a.out_ready = 0;
    bus_b.sel = '0; bus_b.in_data = '0; bus_b.in_valid = 0; bus_b.flush = 0; bus_b.out_ready = 0;
    reset_a = 1; reset_b = 1;
    step();
    reset_a = 0; reset_b = 0;
    step();
    chk_a("reset", 0, 32'h0, 1, 2'd0, 0);

    // streaming, sel=2, continuous drain
    bus_a.in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus_a.sel = 2'd2; bus_a.in_valid = 1; bus_a.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_a($sformatf("stream%0d", i), 1, 32'hA2, 1, 2'd1, 0);
    end
    // varying selects keep order with 1-cycle latency
    bus_a.sel = 2'd0; step(); chk("sel0", bus_a.out_data, 32'hA0);
    bus_a.sel = 2'd3; step(); chk("sel3", bus_a.out_data, 32'hA3);
    bus_a.sel = 2'd1; step(); chk("sel1", bus_a.out_data, 32'hA1);
    bus_a.in_valid = 0;
    step();
    chk_a("drain_hold", 0, 32'hA1, 1, 2'd0, 0);
    bus_a.out_ready = 0; step(); bus_a.out_ready = 1; step(); bus_a.out_ready = 0;
    chk_a("idle_toggle", 0, 32'hA1, 1, 2'd0, 0);

    // backpressure
    offer_a(2'd0, 32'h11); step();
    chk_a("bp1", 1, 32'h11, 1, 2'd1, 0);
    offer_a(2'd0, 32'h22); step();
    chk_a("bp2", 1, 32'h11, 0, 2'd2, 0);
    bus_a.in_valid = 0; step();
    chk_a("bp_hold", 1, 32'h11, 0, 2'd2, 0);
    bus_a.out_ready = 1; step();
    chk_a("bp_drain1", 1, 32'h22, 1, 2'd1, 0);
    step();
    chk_a("bp_drain2", 0, 32'h22, 1, 2'd0, 0);

    // flush while full, colliding with an offered word
    bus_a.out_ready = 0;
    offer_a(2'd1, 32'h55); step();
    offer_a(2'd1, 32'h66); step();
    chk_a("fill_two", 1, 32'h55, 0, 2'd2, 0);
    offer_a(2'd1, 32'h33); bus_a.flush = 1; step();
    chk_a("flush_two", 0, 32'h0, 1, 2'd0, 0);
    bus_a.flush = 0; bus_a.in_valid = 0; bus_a.out_ready = 1; step();
    chk_a("flush_after", 0, 32'h0, 1, 2'd0, 0);

    // flush beats an accept in ONE
    bus_a.out_ready = 0;
    offer_a(2'd2, 32'h77); step();
    offer_a(2'd2, 32'h88); bus_a.flush = 1; step();
    chk_a("flush_one", 0, 32'h0, 1, 2'd0, 0);
    bus_a.flush = 0; bus_a.in_valid = 0; step();
    chk("flush_one_after", 32'(bus_a.out_valid), 32'h0);

    // reset mid-operation
    offer_a(2'd0, 32'h11); step();
    offer_a(2'd0, 32'h22); step();
    offer_a(2'd0, 32'h99); reset_a = 1; bus_a.out_ready = 1; step();
    chk_a("reset_mid", 0, 32'h0, 1, 2'd0, 0);
    reset_a = 0; bus_a.in_valid = 0;

    // illegal select on the 3-input instance
    bus_b.in_data = {32'hB2, 32'hB1, 32'hB0};
    bus_b.sel = 2'd3; bus_b.in_valid = 1; bus_b.flush = 1; step();
    chk("b_flushed_illegal.sel_err", 32'(bus_b.sel_err), 32'h0);
    chk("b_flushed_illegal.valid", 32'(bus_b.out_valid), 32'h0);
    bus_b.flush = 0; step();
    chk("b_illegal.valid", 32'(bus_b.out_valid), 32'h1);
    chk("b_illegal.data", bus_b.out_data, 32'h0);
    chk("b_illegal.sel_err", 32'(bus_b.sel_err), 32'h1);
    bus_b.in_valid = 0; bus_b.flush = 1; step();
    chk("b_flush.sel_err", 32'(bus_b.sel_err), 32'h1);
    chk("b_flush.occ", 32'(bus_b.occupancy), 32'h0);
    bus_b.flush = 0; bus_b.sel = 2'd1; bus_b.in_valid = 1; step();
    chk("b_legal.data", bus_b.out_data, 32'hB1);
    chk("b_legal.sel_err", 32'(bus_b.sel_err), 32'h1);
    bus_b.in_valid = 0; reset_b = 1; step();
    chk("b_reset.sel_err", 32'(bus_b.sel_err), 32'h0);
    chk("b_reset.valid", 32'(bus_b.out_valid), 32'h0);
    reset_b = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe_stage.md
Name: mux_pipe_stage

Overview:
- Parametrised successor to the combinational word multiplexers.
- Selects one of NUM_IN WIDTH-bit inputs and registers the result into a pipeline-stage output.
- Uses a valid/ready handshake with a one-entry skid buffer, so upstream ready is fully registered.
- Supports flush with NOP insertion, for control-signal and operand selection between SPARC pipeline stages.

Parameters:
- WIDTH, 32, bit width of each data input and of the output.
- NUM_IN, 4, number of selectable inputs (2..16).
- SEL_W, $clog2(NUM_IN), select width (derived; do not override).
- NOP_VALUE, {WIDTH{1'b0}}, value driven on out_data after reset/flush and for an illegal select.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- sel  input  SEL_W  input select, sampled with in_valid.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1  upstream offers a word.
- in_ready  output  1  stage can accept; registered.
- flush  input  1  discard all held words.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- occupancy  output  2  words held (0..2).
- sel_err  output  1  sticky flag: an illegal select was accepted.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0, sel_err=0.
  - Skid buffer invalid.
  - Reset overrides every other input, including flush.
- Selection:
  - sel_word = in_data[sel*WIDTH +: WIDTH] when sel < NUM_IN.
  - Otherwise sel_word = NOP_VALUE, and sel_err is set on accept.
  - sel_err stays set until reset.
- Accept event: in_valid & in_ready. Drain event: out_valid & out_ready.
- States (encoded by occupancy):
  - EMPTY (0): accept -> main<=sel_word, go ONE.
  - ONE (1):
    - accept & drain -> main<=sel_word, stay ONE.
    - accept only -> skid<=sel_word, go TWO, in_ready<=0.
    - drain only -> go EMPTY.
  - TWO (2): in_ready=0, so no accept is possible. Drain -> main<=skid, go ONE, in_ready<=1.
- Latency:
  - A word accepted at edge N is visible on out_data/out_valid after edge N (1 cycle) when the stage is EMPTY or draining.
  - Words leave strictly in acceptance order; no word is dropped or duplicated.
- in_ready rules:
  - Driven only from a flop.
  - Equals 1 in EMPTY and ONE, 0 in TWO.
  - Never depends combinationally on out_ready.
- out_data holding:
  - Holds its value while out_valid=1 and out_ready=0.
  - After a drain with no refill, keeps its last value (out_valid=0).
- Flush (edge with flush=1, reset=0):
  - Go EMPTY; out_valid=0, out_data=NOP_VALUE, in_ready=1.
  - Flush beats a simultaneous accept: the word is discarded and sel_err is not updated for it.
  - A simultaneous drain is still considered taken downstream.
- Back-to-back: with out_ready held 1, sustains 1 word/cycle indefinitely.
- out_ready may toggle while out_valid=0 with no effect.
- in_data and sel are don't-care when in_valid=0.

Decomposition:
- Shared package pipe_pkg:
  - occupancy state encoding constants ST_EMPTY=0, ST_ONE=1, ST_TWO=2.
  - Default NOP word constant.
- One natural sub-module, mux_nx1_param: purely combinational N-way selector with WIDTH, NUM_IN and illegal-select detection. It generalises the existing 2x1/4x1 selectors and is reused elsewhere.
- mux_pipe_stage instantiates it and adds the skid/handshake logic.

Test Plan:
- Reset then idle: after reset -> out_valid=0, out_data=0, in_ready=1, occupancy=0, sel_err=0.
- Streaming: WIDTH=32, NUM_IN=4, inputs 0xA0,0xA1,0xA2,0xA3; sel=2 and out_ready=1 for 8 cycles -> out_data=0xA2 one cycle after each accept, out_valid continuous, occupancy=1.
- Backpressure: out_ready=0, offer words 0x11 then 0x22 -> occupancy 1 then 2, in_ready=0, out_data=0x11. Then raise out_ready -> 0x11 then 0x22 emitted in order, in_ready=1 the cycle after the first drain.
- Flush collision: in TWO, assert flush and in_valid together with word 0x33 -> next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0, in_ready=1; 0x33 never appears on the output.
- Illegal select: NUM_IN=3, sel=3 accepted -> out_data=NOP_VALUE with out_valid=1, sel_err=1. sel_err stays 1 through a flush and clears only on reset.
- Reset mid-operation: in TWO, assert reset together with in_valid -> next cycle matches the reset values exactly.
